// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared stage-entry struct, FSM encoding and forward-select constants
package cpu_pkg;

    // Widest register address a stage entry can carry; narrower cores zero-extend.
    localparam int AW_MAX = 8;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              load;
        logic [AW_MAX-1:0] rd;
        logic [AW_MAX-1:0] rs1;
        logic [AW_MAX-1:0] rs2;
        logic              use1;
        logic              use2;
    } stage_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pipe_state_t;

    localparam int FWD_RF = 0;

endpackage

// File: rtl/pipe_match.sv
// rtl/pipe_match.sv - per-operand hazard compare; PIPE_CTRL_FWD_EN selects forwarding vs full interlock
module pipe_match
    import cpu_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 4,
    parameter int FW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    stg_valid,
    input  logic [DEPTH-1:0]    stg_wr,
    input  logic                stg0_load,
    input  logic [DEPTH*AW-1:0] stg_rd,
    input  logic                id_use,
    input  logic [AW-1:0]       id_src,
    input  logic                ex_use,
    input  logic [AW-1:0]       ex_src,
    output logic                stall,
    output logic [FW-1:0]       fwd_sel
);

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic [DEPTH-1:0] hit_id;
    logic [DEPTH-1:0] hit_ex;
    logic [FW-1:0]    youngest;

    always_comb begin
        hit_id = '0;
        hit_ex = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_id[k] = stg_valid[k] & stg_wr[k] & id_use & (stg_rd[k*AW +: AW] == id_src);
            hit_ex[k] = stg_valid[k] & stg_wr[k] & ex_use & (stg_rd[k*AW +: AW] == ex_src);
        end
    end

    // Scan oldest to youngest so the nearest producer overwrites older ones.
    always_comb begin
        youngest = FW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (hit_ex[k]) youngest = FW'(k);
        end
    end

    // Without bypass paths, every writer not yet in WB must drain before ID reads.
    assign fwd_sel = FWD_ON ? youngest : FW'(FWD_RF);
    assign stall   = FWD_ON ? (hit_id[0] & stg0_load) : (|hit_id[DEPTH-2:0]);

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// rtl/cpu_pipe_ctrl.sv - pipeline hazard/flush/halt controller; PIPE_CTRL_FWD_EN enables forwarding
module cpu_pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_wr,
    input  logic                     id_load,
    input  logic                     id_use1,
    input  logic                     id_use2,
    input  logic [REG_AW-1:0]        id_rs1,
    input  logic [REG_AW-1:0]        id_rs2,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     ex_br_taken,
    input  logic                     ex_exc,
    input  logic                     ex_halt,
    output logic                     pc_wr,
    output logic                     ifid_wr,
    output logic                     ifid_flush,
    output logic                     idex_bubble,
    output logic                     pc_sel_br,
    output logic [$clog2(DEPTH)-1:0] fwd_a,
    output logic [$clog2(DEPTH)-1:0] fwd_b,
    output logic                     halted,
    output logic                     exc_flag,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int FW = $clog2(DEPTH);

    pipe_state_t          state;
    stage_t               stg [DEPTH];
    stage_t               id_e;
    logic [DEPTH-1:0]     stg_valid;
    logic [DEPTH-1:0]     stg_wr;
    logic [DEPTH*REG_AW-1:0] stg_rd;
    logic                 stall_a, stall_b;
    logic                 run, halt_req, br, stall_ev;

    always_comb begin
        id_e                   = '0;
        id_e.valid             = id_valid;
        id_e.wr                = id_wr;
        id_e.load              = id_load;
        id_e.rd[REG_AW-1:0]    = id_rd;
        id_e.rs1[REG_AW-1:0]   = id_rs1;
        id_e.rs2[REG_AW-1:0]   = id_rs2;
        id_e.use1              = id_use1 & id_valid;
        id_e.use2              = id_use2 & id_valid;
    end

    always_comb begin
        stg_valid = '0;
        stg_wr    = '0;
        stg_rd    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stg_valid[k]                = stg[k].valid;
            stg_wr[k]                   = stg[k].wr;
            stg_rd[k*REG_AW +: REG_AW]  = stg[k].rd[REG_AW-1:0];
        end
    end

    pipe_match #(.DEPTH(DEPTH), .AW(REG_AW), .FW(FW)) u_match_a (
        .stg_valid (stg_valid),
        .stg_wr    (stg_wr),
        .stg0_load (stg[0].load),
        .stg_rd    (stg_rd),
        .id_use    (id_valid & id_use1),
        .id_src    (id_rs1),
        .ex_use    (stg[0].use1),
        .ex_src    (stg[0].rs1[REG_AW-1:0]),
        .stall     (stall_a),
        .fwd_sel   (fwd_a)
    );

    pipe_match #(.DEPTH(DEPTH), .AW(REG_AW), .FW(FW)) u_match_b (
        .stg_valid (stg_valid),
        .stg_wr    (stg_wr),
        .stg0_load (stg[0].load),
        .stg_rd    (stg_rd),
        .id_use    (id_valid & id_use2),
        .id_src    (id_rs2),
        .ex_use    (stg[0].use2),
        .ex_src    (stg[0].rs2[REG_AW-1:0]),
        .stall     (stall_b),
        .fwd_sel   (fwd_b)
    );

    // Priority: halt beats branch, branch flush beats load-use stall.
    assign run      = (state == ST_RUN);
    assign halt_req = run & stg[0].valid & (ex_exc | ex_halt);
    assign br       = run & ~halt_req & stg[0].valid & ex_br_taken;
    assign stall_ev = run & ~halt_req & ~br & (stall_a | stall_b);
    assign halted   = (state == ST_HALT);

    always_comb begin
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pc_sel_br   = 1'b0;
        if (!run || halt_req) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_bubble = 1'b1;
        end else if (br) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_sel_br   = 1'b1;
        end else if (stall_ev) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            exc_flag  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
        end else begin
            if (halt_req) begin
                state <= ST_HALT;
                if (ex_exc) exc_flag <= 1'b1;
            end
            if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (br && flush_cnt != '1)       flush_cnt <= flush_cnt + 1'b1;
            stg[0] <= idex_bubble ? '0 : id_e;
            for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
        end
    end

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb/tb_cpu_pipe_ctrl.sv - directed bench for cpu_pipe_ctrl (both PIPE_CTRL_FWD_EN builds)
module tb_cpu_pipe_ctrl;

    localparam int REG_AW = 4;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 16;
    localparam int FW     = $clog2(DEPTH);
`ifdef PIPE_CTRL_FWD_EN
    localparam int LU     = 1;
    localparam int LU_FWD = 2;
`else
    localparam int LU     = 2;
    localparam int LU_FWD = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_wr, id_load, id_use1, id_use2;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              ex_br_taken, ex_exc, ex_halt;
    logic              pc_wr, ifid_wr, ifid_flush, idex_bubble, pc_sel_br;
    logic [FW-1:0]     fwd_a, fwd_b;
    logic              halted, exc_flag;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    cpu_pipe_ctrl #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load),
        .id_use1(id_use1), .id_use2(id_use2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_br_taken(ex_br_taken), .ex_exc(ex_exc), .ex_halt(ex_halt),
        .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pc_sel_br(pc_sel_br),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .exc_flag(exc_flag),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input int pcw, input int ifw, input int fl,
                       input int bub, input int sel);
        chk({tag, ".pc_wr"},       32'(pc_wr),       pcw);
        chk({tag, ".ifid_wr"},     32'(ifid_wr),     ifw);
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  fl);
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), bub);
        chk({tag, ".pc_sel_br"},   32'(pc_sel_br),   sel);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    task automatic idle;
        id_valid = 1'b0; id_wr = 1'b0; id_load = 1'b0;
        id_use1  = 1'b0; id_use2 = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    endtask

    task automatic issue(input int wr, input int load, input int rd,
                         input int u1, input int rs1, input int u2, input int rs2);
        id_valid = 1'b1;
        id_wr    = wr[0];
        id_load  = load[0];
        id_rd    = rd[REG_AW-1:0];
        id_use1  = u1[0];
        id_rs1   = rs1[REG_AW-1:0];
        id_use2  = u2[0];
        id_rs2   = rs2[REG_AW-1:0];
    endtask

    initial begin
        rst = 1'b0;
        idle();
        ex_br_taken = 1'b0; ex_exc = 1'b0; ex_halt = 1'b0;
        #12;
        ctl("rst", 1, 1, 0, 0, 0);
        chk("rst.fwd_a", 32'(fwd_a), 0);
        chk("rst.fwd_b", 32'(fwd_b), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.exc_flag", 32'(exc_flag), 0);
        chk("rst.stall_cnt", 32'(stall_cnt), 0);
        chk("rst.flush_cnt", 32'(flush_cnt), 0);
        rst = 1'b1;
        tick();

        // ALU write r2 followed by a read of r2
        issue(1, 0, 2, 0, 0, 0, 0);
        look(); ctl("alu_w", 1, 1, 0, 0, 0);
        tick();
        issue(0, 0, 0, 1, 2, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
        look(); ctl("alu_dep", 1, 1, 0, 0, 0);
        tick(); idle();
        look(); chk("fwd_a.mem", 32'(fwd_a), 1);
        tick(); tick();
        issue(1, 0, 5, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 1, 5, 0, 0); tick(); idle();
        look(); chk("fwd_a.wb", 32'(fwd_a), 2);
        tick(); tick();
        issue(1, 0, 5, 0, 0, 0, 0); tick();
        issue(1, 0, 5, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 1, 5, 0, 0); tick(); idle();
        look(); chk("fwd_a.both", 32'(fwd_a), 1);
        tick(); tick();
`else
        look(); ctl("alu_dep1", 0, 0, 0, 1, 0);
        tick();
        look(); ctl("alu_dep2", 0, 0, 0, 1, 0);
        tick();
        look(); ctl("alu_go", 1, 1, 0, 0, 0);
        exp_stall += 2;
        chk("stall_cnt.alu", 32'(stall_cnt), exp_stall);
        tick(); idle();
        look(); chk("fwd_a.off", 32'(fwd_a), 0);
        tick(); tick();
`endif
        chk("stall_cnt.a", 32'(stall_cnt), exp_stall);

        // load r3 then read r3 on rs2
        issue(1, 1, 3, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 0, 0, 1, 3);
        look(); ctl("lu1", 0, 0, 0, 1, 0);
        tick();
`ifndef PIPE_CTRL_FWD_EN
        look(); ctl("lu2", 0, 0, 0, 1, 0);
        tick();
`endif
        look(); ctl("lu_go", 1, 1, 0, 0, 0);
        exp_stall += LU;
        chk("stall_cnt.lu", 32'(stall_cnt), exp_stall);
        tick(); idle();
        look(); chk("fwd_b.lu", 32'(fwd_b), LU_FWD);
        tick(); tick();

        // invalid ID must not stall even with matching sources
        issue(1, 1, 7, 0, 0, 0, 0); tick();
        idle();
        id_use1 = 1'b1; id_rs1 = 4'd7; id_use2 = 1'b1; id_rs2 = 4'd7;
        look(); ctl("novalid", 1, 1, 0, 0, 0);
        tick(); idle(); tick(); tick();
        chk("stall_cnt.nv", 32'(stall_cnt), exp_stall);

        // taken branch, then taken with EX bubble (ignored)
        issue(0, 0, 0, 0, 0, 0, 0); tick();
        idle(); ex_br_taken = 1'b1;
        look(); ctl("br", 1, 1, 1, 1, 1);
        tick();
        exp_flush += 1;
        look(); ctl("br_bub", 1, 1, 0, 0, 0);
        chk("flush_cnt.br", 32'(flush_cnt), exp_flush);
        ex_br_taken = 1'b0;

        // flush overrides a pending load-use stall
        issue(1, 1, 4, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 1, 4, 0, 0); ex_br_taken = 1'b1;
        look(); ctl("br_ovr", 1, 1, 1, 1, 1);
        tick(); ex_br_taken = 1'b0; idle();
        exp_flush += 1;
        look();
        chk("flush_cnt.ovr", 32'(flush_cnt), exp_flush);
        chk("stall_cnt.ovr", 32'(stall_cnt), exp_stall);
        tick(); tick(); tick();

        // async reset in the middle of a stall
        issue(1, 1, 6, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 1, 6, 0, 0);
        look(); ctl("pre_rst", 0, 0, 0, 1, 0);
        #1 rst = 1'b0;
        #1;
        exp_stall = 0; exp_flush = 0;
        ctl("mid_rst", 1, 1, 0, 0, 0);
        chk("mid_rst.stall_cnt", 32'(stall_cnt), exp_stall);
        chk("mid_rst.flush_cnt", 32'(flush_cnt), exp_flush);
        chk("mid_rst.halted", 32'(halted), 0);
        rst = 1'b1;
        tick();
        look(); ctl("post_rst", 1, 1, 0, 0, 0);
        tick(); idle(); tick();

        // exception together with taken branch: halt wins
        issue(0, 0, 0, 0, 0, 0, 0); tick();
        idle(); ex_exc = 1'b1; ex_br_taken = 1'b1;
        look();
        chk("exc.pc_sel_br", 32'(pc_sel_br), 0);
        chk("exc.ifid_flush", 32'(ifid_flush), 0);
        chk("exc.halted_early", 32'(halted), 0);
        tick(); ex_exc = 1'b0; ex_br_taken = 1'b0;
        look();
        chk("halt.halted", 32'(halted), 1);
        chk("halt.exc_flag", 32'(exc_flag), 1);
        ctl("halt", 0, 0, 0, 1, 0);
        issue(1, 1, 1, 1, 1, 0, 0); ex_br_taken = 1'b1;
        tick(); tick();
        look();
        chk("hold.halted", 32'(halted), 1);
        chk("hold.exc_flag", 32'(exc_flag), 1);
        ctl("hold", 0, 0, 0, 1, 0);
        chk("hold.flush_cnt", 32'(flush_cnt), exp_flush);
        chk("hold.stall_cnt", 32'(stall_cnt), exp_stall);
        ex_br_taken = 1'b0; idle();
        #1 rst = 1'b0;
        #1;
        chk("halt_rst.halted", 32'(halted), 0);
        chk("halt_rst.exc_flag", 32'(exc_flag), 0);
        ctl("halt_rst", 1, 1, 0, 0, 0);
        rst = 1'b1;
        tick();

        // plain halt opcode leaves exc_flag clear
        issue(0, 0, 0, 0, 0, 0, 0); tick();
        idle(); ex_halt = 1'b1;
        tick(); ex_halt = 1'b0;
        look();
        chk("hlt.halted", 32'(halted), 1);
        chk("hlt.exc_flag", 32'(exc_flag), 0);
        chk("hlt.pc_wr", 32'(pc_wr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_pipe_ctrl.md
CPU_PIPE_CTRL -- requirements
Module: cpu_pipe_ctrl

Interface
REQ-001 Parameter REG_AW, 4, register-address width.
REQ-002 Parameter DEPTH, 3, tracked stages after ID (stage0=EX … stage DEPTH-1=WB); legal range 2..8.
REQ-003 Parameter CNT_W, 16, performance-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 id_valid, id_wr, id_load, id_use1, id_use2  input  1 each  ID has instruction, writes rd, is load, reads rs1, reads rs2.
REQ-007 id_rs1, id_rs2, id_rd  input  REG_AW each  ID source/destination registers.
REQ-008 ex_br_taken, ex_exc, ex_halt  input  1 each  EX branch resolved taken, ALU overflow, halt opcode.
REQ-009 pc_wr, ifid_wr, ifid_flush, idex_bubble, pc_sel_br  output  1 each  pipeline-register controls.
REQ-010 fwd_a, fwd_b  output  $clog2(DEPTH)  EX operand source: 0=register file, k=stage k.
REQ-011 halted, exc_flag  output  1 each  core halted; halt caused by exception.
REQ-012 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-013 Each cycle the block SHALL shift an entry {valid, wr, load, rd, rs1, rs2, use1, use2} from ID into stage0 and every stage k into k+1; stage0 SHALL get a bubble (valid=0) when idex_bubble=1.
REQ-014 Load-use: a valid stage0 entry with load=1, wr=1, and rd equal to an ID source whose use bit is set SHALL produce pc_wr=0, ifid_wr=0, idex_bubble=1 for exactly one cycle.
REQ-015 Forwarding SHALL set fwd_a (fwd_b) to the smallest k in 1..DEPTH-1 where stage k is valid, wr=1, rd=stage0.rs1 (rs2), and stage0.use1 (use2)=1; otherwise 0.
REQ-016 Branch: ex_br_taken with stage0 valid SHALL assert ifid_flush=1, idex_bubble=1, pc_sel_br=1, pc_wr=1 in the same cycle; flush SHALL override any stall.
REQ-017 FSM states RUN and HALT; RUN->HALT when stage0 valid and (ex_exc or ex_halt); HALT is left only by reset.
REQ-018 In HALT: pc_wr=0, ifid_wr=0, idex_bubble=1, ifid_flush=0, halted=1; older stages SHALL keep draining.
REQ-019 exc_flag SHALL be set on the RUN->HALT transition when ex_exc=1 and SHALL be sticky.
REQ-020 Simultaneous ex_exc/ex_halt and ex_br_taken: halt wins; pc_sel_br=0.
REQ-021 stall_cnt increments each stall cycle; flush_cnt increments each flush cycle; both saturate at all-ones and do not count in HALT.
REQ-022 ID inputs with id_valid=0 SHALL never cause a stall.
REQ-023 Default outputs in RUN with no hazard: pc_wr=1, ifid_wr=1, all others 0.

Reset
REQ-024 rst low SHALL asynchronously clear all stage entries to invalid, set the FSM to RUN, and clear exc_flag and both counters; outputs SHALL take the REQ-023 defaults.
REQ-025 Reset asserted during a stall or HALT SHALL abort it; the first cycle after release SHALL be RUN with no stall.

Configuration
REQ-026 Macro PIPE_CTRL_FWD_EN defined: forwarding per REQ-015 and stalling per REQ-014.
REQ-027 PIPE_CTRL_FWD_EN undefined: fwd_a=fwd_b=0; ID SHALL stall while any valid writing stage k in 0..DEPTH-2 has rd matching a used ID source; WB (stage DEPTH-1) needs no stall because the register file writes before it reads.

Structure
REQ-028 The stage-entry struct, FSM state encoding, and forwarding-select constants SHALL be in shared package cpu_pkg.
REQ-029 Comparison logic SHALL be one sub-module, pipe_match, instantiated per source operand; it returns the stall condition and the youngest matching stage.

Verification
REQ-030 Load to r3 in EX, ID reads r3 -> one cycle with pc_wr=0, idex_bubble=1, then resume; stall_cnt=1.
REQ-031 FWD_EN, DEPTH=3: r5 written in MEM, EX reads r5 as rs1 -> fwd_a=1; writer in WB only -> fwd_a=2; both MEM and WB write r5 -> fwd_a=1.
REQ-032 ex_br_taken=1 with stage0 valid -> ifid_flush=1, idex_bubble=1, pc_sel_br=1 that cycle; flush_cnt=1.
REQ-033 ex_exc=1 and ex_br_taken=1 together -> next cycle halted=1, exc_flag=1, pc_wr=0, pc_sel_br=0; stays until rst low.
REQ-034 FWD_EN undefined, DEPTH=3: ALU write to r2 then dependent read of r2 -> exactly 2 stall cycles; stall_cnt=2.
REQ-035 rst pulsed low mid-stall -> outputs return to defaults immediately; counters=0; halted=0.
